// File: rtl/fault_campaign_ctrl.sv
// fault_campaign_ctrl
//   Stuck-at fault campaign sequencer. It steps every input vector (outer
//   loop), every fault node 1..NUM_NODES (middle loop) and stuck value 0 then 1
//   (inner loop). For each triple it drives the injection controls, waits
//   SETTLE_CYC cycles, compares the faulty and golden outputs, and streams a
//   valid/ready detection record on each mismatch. It also keeps a per-fault
//   coverage map and a count of the faults detected.
//   Optional feature macro: FCC_FAULT_DROP_EN. When it is defined, a fault that
//   has already been detected is skipped, so each fault yields at most one
//   record.
`timescale 1ns/1ps

module fault_campaign_ctrl #(
  parameter int VEC_W      = 4,
  parameter int NUM_NODES  = 16,
  parameter int SEL_W      = 5,
  parameter int OUT_W      = 2,
  parameter int SETTLE_CYC = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic [VEC_W-1:0]       dut_in,
  output logic [SEL_W-1:0]       flt_sel,
  output logic                   flt_stuck,
  input  logic [OUT_W-1:0]       dut_out,
  input  logic [OUT_W-1:0]       gold_out,
  output logic                   rec_valid,
  input  logic                   rec_ready,
  output logic [VEC_W-1:0]       rec_vec,
  output logic [SEL_W-1:0]       rec_node,
  output logic                   rec_stuck,
  output logic [2*NUM_NODES-1:0] cov_map,
  output logic [SEL_W:0]         det_cnt,
  output logic                   busy,
  output logic                   done
);

  localparam int COV_W = 2 * NUM_NODES;
  localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC + 1) : 1;

`ifdef FCC_FAULT_DROP_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  localparam logic [VEC_W-1:0] VEC_LAST  = {VEC_W{1'b1}};
  localparam logic [VEC_W-1:0] VEC_ONE   = VEC_W'(1);
  localparam logic [SEL_W-1:0] NODE_LAST = SEL_W'(NUM_NODES);
  localparam logic [SEL_W-1:0] NODE_ONE  = SEL_W'(1);
  localparam logic [SEL_W:0]   DET_ONE   = (SEL_W + 1)'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(SETTLE_CYC - 1);
  localparam logic [COV_W-1:0] COV_ONE   = COV_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_SETTLE,
    S_CHECK,
    S_EMIT,
    S_DONE
  } state_t;

  state_t           state;
  logic [VEC_W-1:0] vec_idx;
  logic [SEL_W-1:0] node_idx;
  logic             stuck_idx;
  logic [CNT_W-1:0] settle_cnt;

  logic [VEC_W-1:0] vec_nxt;
  logic [SEL_W-1:0] node_nxt;
  logic             stuck_nxt;
  logic             last_fault;
  logic [SEL_W:0]   cov_idx;
  logic [COV_W-1:0] cov_mask;
  logic             cov_hit;

  // Next campaign indices (stuck inner, node middle, vector outer) and the coverage bit of the current fault.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
    vec_nxt   = vec_idx;
    node_nxt  = node_idx;
    stuck_nxt = ~stuck_idx;
    if (stuck_idx) begin
      if (node_idx == NODE_LAST) begin
        node_nxt = NODE_ONE;
        vec_nxt  = vec_idx + VEC_ONE;
      end else begin
        node_nxt = node_idx + NODE_ONE;
      end
    end
    last_fault = (vec_idx == VEC_LAST) && (node_idx == NODE_LAST) && stuck_idx;
    cov_idx    = {node_idx - NODE_ONE, stuck_idx};
    cov_mask   = COV_ONE << cov_idx;
    cov_hit    = |(cov_map & cov_mask);
  end

  // Campaign FSM with registered injection controls, record port and coverage state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      vec_idx    <= '0;
      node_idx   <= '0;
      stuck_idx  <= 1'b0;
      settle_cnt <= '0;
      dut_in     <= '0;
      flt_sel    <= '0;
      flt_stuck  <= 1'b0;
      rec_valid  <= 1'b0;
      rec_vec    <= '0;
      rec_node   <= '0;
      rec_stuck  <= 1'b0;
      cov_map    <= '0;
      det_cnt    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch reads the state held before this edge.
      case (state)
        S_IDLE, S_DONE: begin
          state <= S_IDLE;
          if (start) begin
            cov_map   <= '0;
            det_cnt   <= '0;
            done      <= 1'b0;
            busy      <= 1'b1;
            vec_idx   <= '0;
            node_idx  <= NODE_ONE;
            stuck_idx <= 1'b0;
            state     <= S_APPLY;
          end
        end

        S_APPLY: begin
          if (DROP_EN && cov_hit) begin
            // Already detected: skip this fault without driving it.
            if (last_fault) begin
              busy      <= 1'b0;
              done      <= 1'b1;
              flt_sel   <= '0;
              flt_stuck <= 1'b0;
              state     <= S_DONE;
            end else begin
              vec_idx   <= vec_nxt;
              node_idx  <= node_nxt;
              stuck_idx <= stuck_nxt;
            end
          end else begin
            dut_in     <= vec_idx;
            flt_sel    <= node_idx;
            flt_stuck  <= stuck_idx;
            settle_cnt <= CNT_LOAD;
            state      <= S_SETTLE;
          end
        end

        S_SETTLE: begin
          if (settle_cnt == '0) begin
            state <= S_CHECK;
          end else begin
            settle_cnt <= settle_cnt - CNT_ONE;
          end
        end

        S_CHECK: begin
          if (dut_out != gold_out) begin
            if (!cov_hit) begin
              det_cnt <= det_cnt + DET_ONE;
            end
            cov_map   <= cov_map | cov_mask;
            rec_vec   <= vec_idx;
            rec_node  <= node_idx;
            rec_stuck <= stuck_idx;
            rec_valid <= 1'b1;
            state     <= S_EMIT;
          end else if (last_fault) begin
            busy      <= 1'b0;
            done      <= 1'b1;
            flt_sel   <= '0;
            flt_stuck <= 1'b0;
            state     <= S_DONE;
          end else begin
            vec_idx   <= vec_nxt;
            node_idx  <= node_nxt;
            stuck_idx <= stuck_nxt;
            state     <= S_APPLY;
          end
        end

        S_EMIT: begin
          // Record and controls stay put until the consumer takes the record.
          if (rec_ready) begin
            rec_valid <= 1'b0;
            if (last_fault) begin
              busy      <= 1'b0;
              done      <= 1'b1;
              flt_sel   <= '0;
              flt_stuck <= 1'b0;
              state     <= S_DONE;
            end else begin
              vec_idx   <= vec_nxt;
              node_idx  <= node_nxt;
              stuck_idx <= stuck_nxt;
              state     <= S_APPLY;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fault_campaign_ctrl.sv
// tb_fault_campaign_ctrl
//   Directed bench for fault_campaign_ctrl. A small behavioural model of the
//   faulty/golden circuit pair drives dut_out/gold_out from the injection
//   controls. A single loop per campaign consumes records and measures the
//   campaign length from the start-acceptance edge.
`timescale 1ns/1ps

module tb_fault_campaign_ctrl;

  localparam int VEC_W      = 4;
  localparam int NUM_NODES  = 16;
  localparam int SEL_W      = 5;
  localparam int OUT_W      = 2;
  localparam int SETTLE_CYC = 2;
  localparam int MAX_CYC    = 4000;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   start;
  logic [VEC_W-1:0]       dut_in;
  logic [SEL_W-1:0]       flt_sel;
  logic                   flt_stuck;
  logic [OUT_W-1:0]       dut_out;
  logic [OUT_W-1:0]       gold_out;
  logic                   rec_valid;
  logic                   rec_ready;
  logic [VEC_W-1:0]       rec_vec;
  logic [SEL_W-1:0]       rec_node;
  logic                   rec_stuck;
  logic [2*NUM_NODES-1:0] cov_map;
  logic [SEL_W:0]         det_cnt;
  logic                   busy;
  logic                   done;

  int n_vec = 0;
  int n_err = 0;
  int mode  = 0;

  logic [VEC_W-1:0] q_vec[$];
  logic [SEL_W-1:0] q_node[$];
  logic             q_stuck[$];

  fault_campaign_ctrl #(
    .VEC_W(VEC_W), .NUM_NODES(NUM_NODES), .SEL_W(SEL_W),
    .OUT_W(OUT_W), .SETTLE_CYC(SETTLE_CYC)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .dut_in(dut_in), .flt_sel(flt_sel), .flt_stuck(flt_stuck),
    .dut_out(dut_out), .gold_out(gold_out),
    .rec_valid(rec_valid), .rec_ready(rec_ready),
    .rec_vec(rec_vec), .rec_node(rec_node), .rec_stuck(rec_stuck),
    .cov_map(cov_map), .det_cnt(det_cnt), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Circuit model: mode 0 never differs, mode 1 differs for node 3 sa1, mode 2 differs on vector 15.
  always_comb begin
    gold_out = '0;
    dut_out  = '0;
    case (mode)
      1: if (flt_sel == 5'd3 && flt_stuck) dut_out = 2'b01;
      2: if (dut_in == 4'hF) dut_out = 2'b10;
      default: dut_out = '0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Run one campaign. Cycles are counted from the edge that accepts start.
  // stall: rec_ready held low this many cycles at the first record.
  // pulse_at: cycle at which a stray start is pulsed (-1 = none).
  // abort_at: return while still busy at this cycle (-1 = run to done).
  task automatic run(input int stall, input int pulse_at, input int abort_at, output int cycles);
    int          stall_left;
    logic [20:0] held;
    bit          fin;
    q_vec.delete();
    q_node.delete();
    q_stuck.delete();
    @(negedge clk);
    start     = 1'b1;
    rec_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_at_start", busy, 1);
    check("done_cleared", done, 0);
    check("det_cleared", det_cnt, 0);
    cycles     = 0;
    stall_left = stall;
    held       = '0;
    fin        = 1'b0;
    while (!fin) begin
      if (cycles == 1) begin
        check("first_vec", dut_in, 0);
        check("first_node", flt_sel, 1);
        check("first_stuck", flt_stuck, 0);
      end
      if (cycles == 5) begin
        check("second_node", flt_sel, 1);
        check("second_stuck", flt_stuck, 1);
      end
      if (rec_valid && stall_left > 0) begin
        if (stall_left == stall)
          held = {rec_valid, rec_vec, rec_node, rec_stuck, flt_sel, flt_stuck, dut_in};
        else
          check("stall_hold", {rec_valid, rec_vec, rec_node, rec_stuck, flt_sel, flt_stuck, dut_in}, held);
        rec_ready  = 1'b0;
        stall_left = stall_left - 1;
      end else begin
        if (rec_valid && stall > 0 && q_vec.size() == 0)
          check("stall_release", {rec_valid, rec_vec, rec_node, rec_stuck, flt_sel, flt_stuck, dut_in}, held);
        rec_ready = 1'b1;
        if (rec_valid) begin
          q_vec.push_back(rec_vec);
          q_node.push_back(rec_node);
          q_stuck.push_back(rec_stuck);
        end
      end
      start = (cycles == pulse_at);
      if (cycles == abort_at) begin
        fin = 1'b1;
      end else if (done) begin
        fin = 1'b1;
      end else if (cycles >= MAX_CYC) begin
        check("timeout_done", done, 1);
        fin = 1'b1;
      end else begin
        @(negedge clk);
        cycles++;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    int cyc;
    rst       = 1'b1;
    start     = 1'b0;
    rec_ready = 1'b0;
    mode      = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sel", flt_sel, 0);
    check("rst_stuck", flt_stuck, 0);
    check("rst_vec", dut_in, 0);
    check("rst_valid", rec_valid, 0);
    check("rst_cov", cov_map, 0);
    check("rst_det", det_cnt, 0);

    // 1: no mismatches at all.
    mode = 0;
    run(0, -1, -1, cyc);
    check("t1_cycles", cyc, 2048);
    check("t1_records", q_vec.size(), 0);
    check("t1_det", det_cnt, 0);
    check("t1_busy", busy, 0);
    check("t1_sel", flt_sel, 0);
    check("t1_done", done, 1);

    // 2: only node 3 sa1 detected, on every vector.
    mode = 1;
    run(0, -1, -1, cyc);
    check("t2_cycles", cyc, 2064);
    check("t2_records", q_vec.size(), 16);
    for (int i = 0; i < q_vec.size(); i++) begin
      check("t2_rec_vec", q_vec[i], i);
      check("t2_rec_node", q_node[i], 3);
      check("t2_rec_stuck", q_stuck[i], 1);
    end
    check("t2_cov", cov_map, 32'h0000_0020);
    check("t2_det", det_cnt, 1);
    repeat (5) @(negedge clk);
    check("t2_cov_persist", cov_map, 32'h0000_0020);
    check("t2_done_persist", done, 1);

    // 3: as 2 with the consumer stalling 10 cycles on the first record.
    run(10, -1, -1, cyc);
    check("t3_cycles", cyc, 2074);
    check("t3_records", q_vec.size(), 16);
    if (q_vec.size() > 0) check("t3_first_vec", q_vec[0], 0);
    check("t3_cov", cov_map, 32'h0000_0020);
    check("t3_det", det_cnt, 1);

    // 4: reset while vector 5 is settling, then a clean repeat of test 1.
    mode = 0;
    run(0, -1, 641, cyc);
    check("t4_vec_before", dut_in, 5);
    check("t4_busy_before", busy, 1);
    rst = 1'b1;
    #1;
    check("t4_busy_rst", busy, 0);
    check("t4_vec_rst", dut_in, 0);
    check("t4_sel_rst", flt_sel, 0);
    @(posedge clk);
    #1;
    check("t4_all_rst", {busy, done, rec_valid, flt_stuck, flt_sel, dut_in, det_cnt}, 0);
    @(negedge clk);
    rst = 1'b0;
    run(0, -1, -1, cyc);
    check("t4_cycles", cyc, 2048);
    check("t4_records", q_vec.size(), 0);
    check("t4_det", det_cnt, 0);

    // 5: stray start while busy must not disturb the campaign.
    run(0, 100, -1, cyc);
    check("t5_cycles", cyc, 2048);
    check("t5_records", q_vec.size(), 0);
    check("t5_det", det_cnt, 0);

    // 6: every fault detected on vector 15 only.
    mode = 2;
    run(0, -1, -1, cyc);
    check("t6_cycles", cyc, 2080);
    check("t6_records", q_vec.size(), 32);
    for (int i = 0; i < q_vec.size(); i++) begin
      check("t6_rec_vec", q_vec[i], 15);
      check("t6_rec_node", q_node[i], i / 2 + 1);
      check("t6_rec_stuck", q_stuck[i], i % 2);
    end
    check("t6_cov", cov_map, 32'hFFFF_FFFF);
    check("t6_det", det_cnt, 32);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
